// File: rtl/commit_trace_capture.sv
// Captures each retired {pc,inst} pair from the core into a FIFO.
// Each pair streams out as two 32-bit beats (pc, then inst) over valid/ready.
module commit_trace_capture #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W:0]   level,
  output logic [31:0]       retired_cnt,
  output logic [DROP_W-1:0] dropped_cnt,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // once out_valid rises, out_data/out_last hold until that transfer.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_PC   = 2'd1,
    SEND_INST = 2'd2
  } state_e;

  localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ZERO   = '0;
  localparam logic [ADDR_W:0]   LVL_ONE    = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE    = 1;
  localparam logic [DROP_W-1:0] DROP_ONE   = 1;
  localparam logic [DROP_W-1:0] DROP_MAX   = '1;

  state_e              state_q, state_d;
  logic [63:0]         mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_next;
  logic [ADDR_W:0]     level_q, level_d;
  logic [31:0]         pc_prev_q;
  logic [31:0]         out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [31:0]         retired_q;
  logic [DROP_W-1:0]   dropped_q;
  logic                overflow_q;
  logic                retire, pop, push;
  logic [31:0]         head_pc, head_inst, next_pc;

  assign retire  = en && (pc != pc_prev_q);
  assign pop     = (state_q == SEND_INST) && out_ready;
  assign push    = retire && ((level_q != FULL_LEVEL) || pop);
  assign rd_next = rd_ptr_q + PTR_ONE;

  assign head_pc   = mem_q[rd_ptr_q][63:32];
  assign head_inst = mem_q[rd_ptr_q][31:0];
  // With one entry left, the only successor is the pair being pushed right now.
  assign next_pc   = (level_q != LVL_ONE) ? mem_q[rd_next][63:32] : pc;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (level_q != LVL_ZERO) begin
          out_data_d  = head_pc;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = SEND_PC;
        end
      end
      SEND_PC: begin
        if (out_ready) begin
          out_data_d = head_inst;
          out_last_d = 1'b1;
          state_d    = SEND_INST;
        end
      end
      SEND_INST: begin
        if (out_ready) begin
          if (level_d != LVL_ZERO) begin
            out_data_d = next_pc;
            out_last_d = 1'b0;
            state_d    = SEND_PC;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pc, inst};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pc_prev_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      retired_q   <= '0;
      dropped_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      pc_prev_q   <= pc;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_next;
      if (retire) retired_q <= retired_q + 32'd1;
      if (retire && !push) begin
        overflow_q <= 1'b1;
        if (dropped_q != DROP_MAX) dropped_q <= dropped_q + DROP_ONE;
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign level       = level_q;
  assign retired_cnt = retired_q;
  assign dropped_cnt = dropped_q;
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_commit_trace_capture.sv
// Bench for commit_trace_capture: directed sequences, a vector table and a
// randomized run, all checked against a queue-based model of the trace stream.
module tb_commit_trace_capture;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DROP_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [31:0]       pc, inst;
  logic [31:0]       out_data;
  logic              out_valid, out_ready, out_last;
  logic [ADDR_W:0]   level;
  logic [31:0]       retired_cnt;
  logic [DROP_W-1:0] dropped_cnt;
  logic              overflow;
  logic [1:0]        dbg_state;

  commit_trace_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset(reset), .en(en), .pc(pc), .inst(inst),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .level(level), .retired_cnt(retired_cnt), .dropped_cnt(dropped_cnt),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model
  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc_prev;
  int          m_level;
  logic [31:0] m_retired;
  int          m_dropped;
  logic        m_overflow;
  logic        m_phase;
  logic        prev_ok, prev_stall, prev_last;
  logic [31:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc_prev  = '0;
    m_level    = 0;
    m_retired  = '0;
    m_dropped  = 0;
    m_overflow = 1'b0;
    m_phase    = 1'b0;
    exp_q.delete();
    prev_ok    = 1'b0;
  endtask

  // One clock: score any beat handshaking this edge, advance the model, check after the edge.
  task automatic cycle();
    logic        hs, hs_last, retire;
    logic [31:0] exp_beat;
    hs      = (out_valid === 1'b1) && (out_ready === 1'b1);
    hs_last = 1'b0;
    if (hs) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_beat: got 0x%08h expected no beat", out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        chk("beat_data", out_data, exp_beat);
        chk("beat_last", {31'd0, out_last}, {31'd0, m_phase});
      end
      hs_last = m_phase;
      m_phase = ~m_phase;
    end
    retire    = en && (pc != m_pc_prev);
    m_pc_prev = pc;
    if (retire) begin
      m_retired = m_retired + 32'd1;
      if (m_level < DEPTH || hs_last) begin
        exp_q.push_back(pc);
        exp_q.push_back(inst);
        m_level++;
      end else begin
        if (m_dropped < (1 << DROP_W) - 1) m_dropped++;
        m_overflow = 1'b1;
      end
    end
    if (hs_last) m_level--;
    prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
    prev_data  = out_data;
    prev_last  = out_last;
    @(posedge clk);
    #1;
    chk("level", {27'd0, level}, m_level);
    chk("retired_cnt", retired_cnt, m_retired);
    chk("dropped_cnt", {16'd0, dropped_cnt}, m_dropped);
    chk("overflow", {31'd0, overflow}, {31'd0, m_overflow});
    if (prev_ok && prev_stall) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, prev_data);
      chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
    end
    prev_ok = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || m_level != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0 || m_level != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d beats left, expected 0 within %0d cycles", exp_q.size(), max_cycles);
    end
    chk("drain_level", {27'd0, level}, 32'd0);
    chk("drain_idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  typedef struct {
    logic            en;
    logic [31:0]     pc;
    logic [ADDR_W:0] exp_level;
    logic [31:0]     exp_ret;
    logic            exp_valid;
    logic [31:0]     exp_data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic vld[14];
    int   first_v, last_v, cnt_v;
    int   bias;

    vecs[0] = '{1'b0, 32'h100, 5'd0, 32'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h104, 5'd0, 32'd0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h108, 5'd0, 32'd0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 32'h108, 5'd0, 32'd0, 1'b0, 32'h0};
    vecs[4] = '{1'b1, 32'h10c, 5'd1, 32'd1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h10c, 5'd1, 32'd1, 1'b1, 32'h10c};
    vecs[6] = '{1'b1, 32'h110, 5'd2, 32'd2, 1'b1, 32'h10c};
    vecs[7] = '{1'b0, 32'h114, 5'd2, 32'd2, 1'b1, 32'h10c};
    vecs[8] = '{1'b1, 32'h114, 5'd2, 32'd2, 1'b1, 32'h10c};
    vecs[9] = '{1'b1, 32'h000, 5'd3, 32'd3, 1'b1, 32'h10c};

    tests_run    = 0;
    tests_failed = 0;
    model_reset();

    // T1: reset values, first capture and first pair
    reset = 1'b0; en = 1'b1; pc = 32'h0040_0000; inst = 32'h3c01_0040; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_data", out_data, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_dropped", {16'd0, dropped_cnt}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    cycle();
    chk("t1_level", {27'd0, level}, 32'd1);
    chk("t1_retired", retired_cnt, 32'd1);
    out_ready = 1'b1;
    cycle();
    chk("t1_pc_beat", out_data, 32'h0040_0000);
    chk("t1_pc_last", {31'd0, out_last}, 32'd0);
    cycle();
    chk("t1_inst_beat", out_data, 32'h3c01_0040);
    chk("t1_inst_last", {31'd0, out_last}, 32'd1);
    cycle();
    chk("t1_done_valid", {31'd0, out_valid}, 32'd0);

    // T2: five retirements stream as ten consecutive beats
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 5) begin
        pc   = 32'h1000 + 32'(4 * i);
        inst = $urandom;
      end
      cycle();
      vld[i] = out_valid;
    end
    first_v = -1; last_v = -1; cnt_v = 0;
    for (int i = 0; i < 14; i++) begin
      if (vld[i]) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        cnt_v++;
      end
    end
    chk("t2_valid_cycles", cnt_v, 32'd10);
    chk("t2_no_bubble_span", last_v - first_v + 1, 32'd10);
    chk("t2_first_valid_cycle", first_v, 32'd1);
    chk("t2_level", {27'd0, level}, 32'd0);

    // T3: 18 retirements with the consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      pc   = 32'h2000 + 32'(4 * i);
      inst = $urandom;
      cycle();
    end
    chk("t3_level", {27'd0, level}, 32'd16);
    chk("t3_dropped", {16'd0, dropped_cnt}, 32'd2);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_retired", retired_cnt, 32'd18);
    drain(100);

    // T4: push into a full FIFO on the same edge the head inst beat completes
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pc   = 32'h3000 + 32'(4 * i);
      inst = $urandom;
      cycle();
    end
    cycle();
    out_ready = 1'b1;
    cycle();
    pc = 32'h0003_fff0;
    inst = 32'hdead_beef;
    cycle();
    chk("t4_level", {27'd0, level}, 32'd16);
    chk("t4_dropped", {16'd0, dropped_cnt}, 32'd0);
    chk("t4_next_pc", out_data, 32'h3004);
    chk("t4_next_valid", {31'd0, out_valid}, 32'd1);
    drain(100);

    // T5 and capture latency, as a vector table (consumer stalled)
    pc = 32'h100;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en   = vecs[i].en;
      pc   = vecs[i].pc;
      inst = ~vecs[i].pc;
      cycle();
      chk("vec_level", {27'd0, level}, {27'd0, vecs[i].exp_level});
      chk("vec_retired", retired_cnt, vecs[i].exp_ret);
      chk("vec_valid", {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
      chk("vec_data", out_data, vecs[i].exp_data);
    end
    drain(100);

    // T6: asynchronous reset while the inst beat is stalled
    do_reset();
    en = 1'b1; out_ready = 1'b1; pc = 32'h5000; inst = 32'h1111_2222;
    cycle();
    cycle();
    cycle();
    out_ready = 1'b0;
    cycle();
    chk("t6_stalled_last", {31'd0, out_last}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_level", {27'd0, level}, 32'd0);
    chk("t6_async_last", {31'd0, out_last}, 32'd0);
    model_reset();
    pc = 32'h6000; inst = 32'h3333_4444;
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("t6_restart_pc", out_data, 32'h6000);
    chk("t6_restart_last", {31'd0, out_last}, 32'd0);
    drain(100);

    // randomized traffic with varying consumer throughput
    do_reset();
    bias = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) bias = (i / 100) % 3 == 0 ? 10 : ((i / 100) % 3 == 1 ? 50 : 90);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) pc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      inst = $urandom;
      out_ready = ($urandom_range(0, 99) < bias);
      cycle();
    end
    en = 1'b0;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
